muldiv_ctrl: RTL and testbench

Sequencer and owner of the HI/LO register pair for the CPU's multi-cycle arithmetic units. It accepts MULT/DIV requests from the main control unit and launches the multiplier or divider with level-held start signals and stable latched operands. It waits for each unit's done flag, commits HI/LO or raises the divide-by-zero exception, and drives the stall used by MFHI/MFLO and by back-to-back mult/div instructions.

---
 rtl/muldiv_ctrl.sv | 123 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multiplier/divider units and owner of the architectural HI/LO pair.
// Optional watchdog on the WAIT state is enabled with `define MULDIV_TIMEOUT_EN.
module muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_sel,
  output logic        op_ready,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  output logic [31:0] opa_out,
  output logic [31:0] opb_out,
  output logic        mult_ctrl,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_ctrl,
  input  logic        div_done,
  input  logic        div0,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done_pulse,
  output logic        div0_exc,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_e;

  state_e      state_q;
  logic        cur_div_q;
  logic [31:0] opa_q, opb_q, hi_q, lo_q;
  logic        done_pulse_q, div0_exc_q;
  logic        sel_done;

  // Only the launched unit's done flag is ever looked at.
  assign sel_done = cur_div_q ? div_done : mult_done;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_div_q    <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      done_pulse_q <= 1'b0;
      div0_exc_q   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      done_pulse_q <= 1'b0;
      div0_exc_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_valid) begin
            opa_q     <= rs_in;
            opb_q     <= rt_in;
            cur_div_q <= op_sel;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT;
`ifdef MULDIV_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT: begin
          if (sel_done) begin
            if (cur_div_q && div0) begin
              div0_exc_q <= 1'b1;
            end else begin
              hi_q         <= cur_div_q ? div_hi : mult_hi;
              lo_q         <= cur_div_q ? div_lo : mult_lo;
              done_pulse_q <= 1'b1;
            end
            state_q <= RELEASE;
          end
`ifdef MULDIV_TIMEOUT_EN
          // Give up after TIMEOUT_CYCLES WAIT cycles with no done; HI/LO untouched.
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= RELEASE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control levels are pure decodes of registered state; no input-to-output paths.
  assign op_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mult_ctrl  = ((state_q == LAUNCH) || (state_q == WAIT)) && !cur_div_q;
  assign div_ctrl   = ((state_q == LAUNCH) || (state_q == WAIT)) &&  cur_div_q;
  assign opa_out    = opa_q;
  assign opb_out    = opb_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign done_pulse = done_pulse_q;
  assign div0_exc   = div0_exc_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl; acts as both arithmetic units and tracks HI/LO
// with a transaction-level model computed from plain signed arithmetic.
module tb_muldiv_ctrl;

  logic        clock = 1'b0, reset;
  logic        op_valid, op_sel, op_ready;
  logic [31:0] rs_in, rt_in, opa_out, opb_out;
  logic        mult_ctrl, mult_done, div_ctrl, div_done, div0;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo, hi_out, lo_out;
  logic        busy, done_pulse, div0_exc, timeout_err;

  int          n_err = 0, n_chk = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        exp_tmo = 1'b0;

  always #5 clock = ~clock;

  muldiv_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_sel(op_sel), .op_ready(op_ready),
    .rs_in(rs_in), .rt_in(rt_in), .opa_out(opa_out), .opb_out(opb_out),
    .mult_ctrl(mult_ctrl), .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_ctrl(div_ctrl), .div_done(div_done), .div0(div0), .div_hi(div_hi), .div_lo(div_lo),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done_pulse(done_pulse),
    .div0_exc(div0_exc), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic junk_done();
    mult_done = 1'($urandom); div_done = 1'($urandom); div0 = 1'($urandom);
  endtask

  // One complete MULT/DIV transaction; when chain=1 the next request is held during busy.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b, input int lat,
                        input bit chain, input bit nsel, input logic [31:0] na, input logic [31:0] nb);
    int     sa, sb, q, r;
    longint p;
    bit     z;
    sa = a; sb = b;
    z  = sel && (b == 0);
    p  = longint'(sa) * longint'(sb);
    q  = z ? 0 : sa / sb;
    r  = z ? 0 : sa % sb;
    chk("ready_pre", op_ready, 1'b1);
    op_valid = 1'b1; op_sel = sel; rs_in = a; rt_in = b;
    step();
    // LAUNCH
    if (chain) begin
      op_sel = nsel; rs_in = na; rt_in = nb;
    end else begin
      op_valid = 1'($urandom); op_sel = 1'($urandom); rs_in = $urandom; rt_in = $urandom;
    end
    mult_hi = p[63:32]; mult_lo = p[31:0];
    div_hi  = (sel && !z) ? r : $urandom;
    div_lo  = (sel && !z) ? q : $urandom;
    chk("launch_busy", {busy, op_ready}, 2'b10);
    chk("launch_ctrl", {mult_ctrl, div_ctrl}, {!sel, sel});
    chk("launch_opa", opa_out, a);
    chk("launch_opb", opb_out, b);
    junk_done();
    step();
    for (int k = 1; k <= lat; k++) begin
      chk("wait_ctrl", {mult_ctrl, div_ctrl, busy}, {!sel, sel, 1'b1});
      chk("wait_hilo", {hi_out, lo_out}, {m_hi, m_lo});
      chk("wait_pulse", {done_pulse, div0_exc}, 2'b00);
      chk("wait_opa", {opa_out, opb_out}, {a, b});
      if (sel) begin
        div_done = (k == lat); mult_done = 1'($urandom);
        div0 = (k == lat) ? z : 1'($urandom);
      end else begin
        mult_done = (k == lat); div_done = 1'($urandom); div0 = 1'($urandom);
      end
      step();
    end
    // RELEASE
    if (!z) begin
      m_hi = sel ? r : p[63:32];
      m_lo = sel ? q : p[31:0];
    end
    chk("rel_ctrl", {mult_ctrl, div_ctrl, busy, op_ready}, 4'b0010);
    chk("rel_pulse", {done_pulse, div0_exc}, {!z, z});
    chk("rel_hilo", {hi_out, lo_out}, {m_hi, m_lo});
    chk("rel_opa", {opa_out, opb_out}, {a, b});
    if (!chain) op_valid = 1'b0;
    junk_done();
    step();
    // IDLE
    chk("idle_state", {op_ready, busy, mult_ctrl, div_ctrl}, 4'b1000);
    chk("idle_pulse", {done_pulse, div0_exc, timeout_err}, {2'b00, exp_tmo});
    chk("idle_hilo", {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  initial begin
    bit          sel, nsel, chain;
    logic [31:0] a, b, na, nb;
    reset = 1'b1; op_valid = 1'b0; op_sel = 1'b0; rs_in = '0; rt_in = '0;
    mult_done = 1'b0; div_done = 1'b0; div0 = 1'b0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", {op_ready, busy, mult_ctrl, div_ctrl, done_pulse, div0_exc, timeout_err}, 7'b1000000);
    chk("rst_regs", {hi_out, lo_out, opa_out, opb_out}, 128'd0);

    // Directed cases from the plan.
    run_op(1'b0, 32'd7, 32'd6, 3, 1'b0, 1'b0, '0, '0);
    chk("plan_mult", {hi_out, lo_out}, {32'd0, 32'd42});
    run_op(1'b1, 32'd9, 32'd0, 1, 1'b0, 1'b0, '0, '0);
    chk("plan_div0_keep", {hi_out, lo_out}, {32'd0, 32'd42});
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 2, 1'b1, 1'b0, 32'd100, 32'd3);
    chk("plan_div", {hi_out, lo_out}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1'b0, 32'd100, 32'd3, 1, 1'b0, 1'b0, '0, '0);
    chk("plan_chain", {hi_out, lo_out}, {32'd0, 32'd300});

    // Reset mid-WAIT, then a late done that must be ignored.
    op_valid = 1'b1; op_sel = 1'b0; rs_in = 32'd5; rt_in = 32'd5;
    mult_done = 1'b0; div_done = 1'b0;
    step(); op_valid = 1'b0; step(); step();
    chk("pre_rst_wait", {mult_ctrl, busy}, 2'b11);
    reset = 1'b1;
    step();
    reset = 1'b0; m_hi = '0; m_lo = '0;
    chk("midrst_state", {op_ready, busy, mult_ctrl, div_ctrl, done_pulse, div0_exc}, 6'b100000);
    chk("midrst_regs", {hi_out, lo_out, opa_out, opb_out}, 128'd0);
    mult_done = 1'b1; div_done = 1'b1; mult_hi = 32'hDEAD; mult_lo = 32'hBEEF;
    step(); step();
    chk("late_done", {op_ready, done_pulse, hi_out, lo_out}, {2'b10, 64'd0});

    // Randomized traffic, optionally back-to-back.
    sel = 1'($urandom); a = $urandom; b = $urandom;
    for (int i = 0; i < 40; i++) begin
      chain = 1'($urandom);
      nsel = 1'($urandom); na = $urandom;
      nb = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      if (nb == 32'hFFFF_FFFF) nb = 32'd1;
      if (b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(sel, a, b, $urandom_range(6, 1), chain, nsel, na, nb);
      if (!chain && $urandom_range(1)) begin
        step();
        chk("gap_idle", {op_ready, busy}, 2'b10);
      end
      sel = nsel; a = na; b = nb;
    end
    op_valid = 1'b0;

`ifdef MULDIV_TIMEOUT_EN
    // Watchdog: done never arrives; 8 WAIT cycles then RELEASE with the sticky error.
    mult_done = 1'b0; div_done = 1'b0;
    op_valid = 1'b1; op_sel = 1'b0; rs_in = 32'd3; rt_in = 32'd3;
    step(); op_valid = 1'b0; step();
    for (int k = 0; k < 8; k++) begin
      chk("tmo_wait", {busy, mult_ctrl, timeout_err}, 3'b110);
      step();
    end
    exp_tmo = 1'b1;
    chk("tmo_rel", {timeout_err, mult_ctrl, busy, done_pulse}, 4'b1010);
    chk("tmo_hilo", {hi_out, lo_out}, {m_hi, m_lo});
    step();
    chk("tmo_idle", {op_ready, timeout_err}, 2'b11);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
